// File: rtl/varwidth_fifo_reader.sv
// Drains the packed capture BRAM into one sample per beat: pre-trigger ring (oldest first), then main region.
// First beat valid 2 cycles after the start-accepting edge; 2 idle cycles per word; holds dout while stalled.
module varwidth_fifo_reader #(
    parameter int addr_width    = 11,
    parameter int data_width    = 10,
    parameter int pad_width     = 2,
    parameter int data_per_addr = 3,
    localparam int SW           = data_width + pad_width,
    localparam int WW           = data_per_addr * SW
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  circ_full,
    input  logic [addr_width-1:0] circ_addr,
    input  logic [4:0]            circ_ws,
    input  logic [addr_width-1:0] max_circ_addr,
    input  logic [4:0]            max_circ_ws,
    input  logic [31:0]           circ_count,
    input  logic [31:0]           total_samples,
    output logic                  bram_en,
    output logic [addr_width-1:0] bram_addr,
    input  logic [WW-1:0]         bram_data,
    output logic [data_width-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_UNPACK, S_DONE} state_t;

    localparam logic [addr_width-1:0] A_ONE   = {{(addr_width-1){1'b0}}, 1'b1};
    localparam logic [4:0]            WS_LAST = 5'(data_per_addr - 1);

    state_t                  r_state, w_next_state;
    logic                    r_main;
    logic [addr_width-1:0]   r_addr;
    logic [4:0]              r_ws;
    logic [addr_width-1:0]   r_max_addr;
    logic [4:0]              r_max_ws;
    logic [31:0]             r_rem;
    logic [31:0]             r_pre_rem;
    logic [data_per_addr-1:0][data_width-1:0] r_slots;

    logic                    w_accept;
    logic                    w_hs;
    logic                    w_ring_end;
    logic                    w_word_end;
    logic [31:0]             w_pre_n;
    logic [data_width-1:0]   w_slot;
    logic                    w_pad_unused;

    assign w_accept   = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_hs       = (r_state == S_UNPACK) && dout_ready;
    assign w_ring_end = (r_addr == r_max_addr) && (r_ws == r_max_ws);
    assign w_word_end = (r_ws == WS_LAST);
    assign w_pre_n    = (circ_count < total_samples) ? circ_count : total_samples;

    always_comb begin
        w_slot       = '0;
        w_pad_unused = 1'b0;
        for (int k = 0; k < data_per_addr; k++) begin
            if (r_ws == 5'(k)) w_slot = r_slots[k];
            w_pad_unused = w_pad_unused ^ (^bram_data[k*SW+data_width +: pad_width]);
        end
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        bram_en      = 1'b0;
        bram_addr    = r_addr;
        dout_valid   = 1'b0;
        dout         = '0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                done = (r_state == S_DONE);
                if (w_accept) w_next_state = (total_samples == 32'd0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                busy         = 1'b1;
                bram_en      = 1'b1;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                busy         = 1'b1;
                w_next_state = S_UNPACK;
            end
            S_UNPACK: begin
                busy       = 1'b1;
                dout_valid = 1'b1;
                dout       = w_slot;
                if (w_hs) begin
                    if (r_rem == 32'd1)
                        w_next_state = S_DONE;
                    else if (!r_main && (r_pre_rem == 32'd1 || w_ring_end || w_word_end))
                        w_next_state = S_FETCH;
                    else if (r_main && w_word_end)
                        w_next_state = S_FETCH;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main     <= 1'b0;
            r_addr     <= '0;
            r_ws       <= '0;
            r_max_addr <= '0;
            r_max_ws   <= '0;
            r_rem      <= '0;
            r_pre_rem  <= '0;
            r_slots    <= '0;
        end else begin
            if (w_accept) begin
                r_max_addr <= max_circ_addr;
                r_max_ws   <= max_circ_ws;
                r_rem      <= total_samples;
                r_pre_rem  <= w_pre_n;
                if (w_pre_n == 32'd0) begin
                    r_main <= 1'b1;
                    r_addr <= max_circ_addr + A_ONE;
                    r_ws   <= '0;
                end else begin
                    r_main <= 1'b0;
                    r_addr <= circ_full ? circ_addr : '0;
                    r_ws   <= circ_full ? circ_ws : '0;
                end
            end
            if (r_state == S_WAIT) begin
                for (int k = 0; k < data_per_addr; k++)
                    r_slots[k] <= bram_data[k*SW +: data_width];
            end
            if (w_hs) begin
                r_rem <= r_rem - 32'd1;
                if (!r_main) begin
                    r_pre_rem <= r_pre_rem - 32'd1;
                    // Last pre-trigger sample hands over to the main region right after the ring
                    if (r_pre_rem == 32'd1) begin
                        r_main <= 1'b1;
                        r_addr <= r_max_addr + A_ONE;
                        r_ws   <= '0;
                    end else if (w_ring_end) begin
                        r_addr <= '0;
                        r_ws   <= '0;
                    end else if (w_word_end) begin
                        r_addr <= r_addr + A_ONE;
                        r_ws   <= '0;
                    end else begin
                        r_ws <= r_ws + 5'd1;
                    end
                end else if (w_word_end) begin
                    r_addr <= r_addr + A_ONE;
                    r_ws   <= '0;
                end else begin
                    r_ws <= r_ws + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_varwidth_fifo_reader.sv
// Bench for varwidth_fifo_reader: behavioural BRAM, order model feeding a scoreboard queue.
module tb_varwidth_fifo_reader;

    localparam int AW  = 11;
    localparam int DW  = 10;
    localparam int PW  = 2;
    localparam int DPA = 3;
    localparam int SW  = DW + PW;
    localparam int WW  = DPA * SW;

    logic          rd_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          circ_full = 1'b0;
    logic [AW-1:0] circ_addr = '0;
    logic [4:0]    circ_ws = '0;
    logic [AW-1:0] max_circ_addr = '0;
    logic [4:0]    max_circ_ws = '0;
    logic [31:0]   circ_count = '0;
    logic [31:0]   total_samples = '0;
    logic          bram_en;
    logic [AW-1:0] bram_addr;
    logic [WW-1:0] bram_data = '0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic          busy;
    logic          done;

    always #5 rd_clk = ~rd_clk;

    varwidth_fifo_reader #(
        .addr_width(AW), .data_width(DW), .pad_width(PW), .data_per_addr(DPA)
    ) dut (
        .rd_clk(rd_clk), .rst_n(rst_n), .start(start), .circ_full(circ_full),
        .circ_addr(circ_addr), .circ_ws(circ_ws), .max_circ_addr(max_circ_addr),
        .max_circ_ws(max_circ_ws), .circ_count(circ_count), .total_samples(total_samples),
        .bram_en(bram_en), .bram_addr(bram_addr), .bram_data(bram_data), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy), .done(done)
    );

    function automatic logic [DW-1:0] sval(int a, int s);
        return 10'((a * 37 + s * 301 + 11) % 1024);
    endfunction

    function automatic logic [WW-1:0] mkword(int a);
        logic [WW-1:0] w;
        w = '1;
        for (int k = 0; k < DPA; k++) w[k*SW +: DW] = sval(a, k);
        return w;
    endfunction

    always @(posedge rd_clk) if (bram_en) bram_data <= mkword(int'(bram_addr));

    typedef struct {
        bit full;
        int ca, cw, mca, mcw, cc, tot;
        int ready_mode;
        bit poke;
        int exp_fetches;
        int exp_last_a, exp_last_s;
    } vec_t;

    vec_t vt[7];
    int   exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_expected(vec_t v);
        int pre_n, a, s;
        pre_n = (v.cc < v.tot) ? v.cc : v.tot;
        a = v.full ? v.ca : 0;
        s = v.full ? v.cw : 0;
        for (int i = 0; i < pre_n; i++) begin
            exp_q.push_back(a * 4 + s);
            if (a == v.mca && s == v.mcw) begin a = 0; s = 0; end
            else if (s == DPA - 1)        begin a = (a + 1) % 2048; s = 0; end
            else                          s++;
        end
        a = (v.mca + 1) % 2048;
        s = 0;
        for (int i = 0; i < v.tot - pre_n; i++) begin
            exp_q.push_back(a * 4 + s);
            if (s == DPA - 1) begin a = (a + 1) % 2048; s = 0; end
            else              s++;
        end
    endtask

    task automatic drive_inputs(vec_t v);
        circ_full     = v.full;
        circ_addr     = 11'(v.ca);
        circ_ws       = 5'(v.cw);
        max_circ_addr = 11'(v.mca);
        max_circ_ws   = 5'(v.mcw);
        circ_count    = 32'(v.cc);
        total_samples = 32'(v.tot);
    endtask

    task automatic run_vec(int idx);
        vec_t v;
        int cyc, fetches, first_vld, last, code;
        logic prev_stall;
        logic [DW-1:0] prev_dout;
        v = vt[idx];
        @(negedge rd_clk);
        drive_inputs(v);
        start = 1'b1;
        push_expected(v);
        @(posedge rd_clk);
        @(negedge rd_clk);
        chk("fetch_on_accept", int'(bram_en), 1);
        chk("busy_on_accept", int'(busy), 1);
        cyc = 0; fetches = 0; first_vld = -1; last = -1;
        prev_stall = 1'b0; prev_dout = '0;
        while (!done && cyc < 2000) begin
            start = 1'b0;
            if (v.poke && cyc == 8) begin
                start = 1'b1;
                circ_count = 32'd1;
                total_samples = 32'd2;
                max_circ_addr = 11'd500;
            end
            if (bram_en) fetches++;
            if (dout_valid && first_vld < 0) first_vld = cyc;
            if (prev_stall) begin
                chk("stall_hold_vld", int'(dout_valid), 1);
                chk("stall_hold_dat", int'(dout), int'(prev_dout));
            end
            case (v.ready_mode)
                0:       dout_ready = 1'b1;
                1:       dout_ready = !(cyc >= 4 && cyc < 9);
                default: dout_ready = 1'($urandom_range(0, 1));
            endcase
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) chk("extra_beat", 1, 0);
                else begin
                    code = exp_q.pop_front();
                    chk("beat", int'(dout), int'(sval(code / 4, code % 4)));
                    last = code;
                end
            end
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
            @(negedge rd_clk);
            cyc++;
        end
        start = 1'b0;
        dout_ready = 1'b0;
        chk("done_reached", int'(done), 1);
        chk("busy_after", int'(busy), 0);
        chk("leftover_samples", exp_q.size(), 0);
        chk("fetch_count", fetches, v.exp_fetches);
        chk("first_valid_latency", first_vld, 2);
        chk("last_sample", last, v.exp_last_a * 4 + v.exp_last_s);
        exp_q.delete();
    endtask

    task automatic chk_outputs_zero(string tag);
        chk({tag, "_bram_en"}, int'(bram_en), 0);
        chk({tag, "_bram_addr"}, int'(bram_addr), 0);
        chk({tag, "_dout"}, int'(dout), 0);
        chk({tag, "_dout_valid"}, int'(dout_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        //        full ca cw  mca  mcw cc  tot mode poke fetch lastA lastS
        vt[0] = '{1'b0, 0, 0,    1, 0,  4, 10, 1, 1'b0, 4, 3, 2};
        vt[1] = '{1'b1, 1, 1,    2, 2,  9, 12, 0, 1'b0, 5, 3, 2};
        vt[2] = '{1'b0, 0, 0,    9, 2, 20,  5, 2, 1'b0, 2, 1, 1};
        vt[3] = '{1'b0, 0, 0,    4, 0,  0,  4, 0, 1'b0, 2, 6, 0};
        vt[4] = '{1'b0, 0, 0, 2047, 1,  0,  3, 0, 1'b0, 1, 0, 2};
        vt[5] = '{1'b1, 3, 0,    3, 0,  5,  6, 2, 1'b0, 4, 4, 0};
        vt[6] = '{1'b0, 0, 0,    1, 0,  4, 10, 0, 1'b1, 4, 3, 2};

        #1;
        chk_outputs_zero("reset");
        repeat (3) @(posedge rd_clk);
        @(negedge rd_clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(i);

        // Zero-length drain from DONE: straight back to DONE, no BRAM access
        @(negedge rd_clk);
        total_samples = 32'd0;
        start = 1'b1;
        @(posedge rd_clk);
        @(negedge rd_clk);
        start = 1'b0;
        chk("zero_done", int'(done), 1);
        chk("zero_busy", int'(busy), 0);
        begin
            int en_seen;
            en_seen = 0;
            for (int i = 0; i < 6; i++) begin
                if (bram_en || dout_valid) en_seen++;
                @(negedge rd_clk);
            end
            chk("zero_no_activity", en_seen, 0);
        end

        // Asynchronous reset in the middle of unpacking, then a clean full drain
        drive_inputs(vt[1]);
        start = 1'b1;
        @(posedge rd_clk);
        @(negedge rd_clk);
        start = 1'b0;
        dout_ready = 1'b1;
        for (int i = 0; i < 20 && !dout_valid; i++) @(negedge rd_clk);
        chk("reach_unpack", int'(dout_valid), 1);
        @(posedge rd_clk);
        #2 rst_n = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        dout_ready = 1'b0;
        @(negedge rd_clk);
        rst_n = 1'b1;
        run_vec(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
